lcd_hd44780_ctrl: RTL

Avalon-MM slave that turns single-byte instruction/data writes into HD44780-compatible character-LCD bus cycles with correct setup, enable-pulse, hold and execution delays. It sits directly downstream of the LCD display driver: it consumes that driver's Avalon-MM write stream and drives the LCD pins. After reset it runs the LCD power-on initialisation on its own, and holds off the bus until that completes.

---
 rtl/lcd_inst_pkg.sv | 41 ++++
 rtl/lcd_delay_timer.sv | 32 +++
 rtl/lcd_hd44780_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lcd_inst_pkg.sv
// Shared types for the HD44780 controller: 9-bit {RS, byte} instruction word,
// controller states and the power-on initialisation ROM.
package lcd_inst_pkg;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_inst_t;

    typedef enum logic [2:0] {
        INIT_WAIT,
        INIT_CMD,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC_WAIT
    } state_t;

    localparam int N_INIT = 6;

    // Function set 8-bit/2-line (x3), display on, clear, entry mode increment.
    localparam lcd_inst_t INIT_ROM [N_INIT] = '{
        '{1'b0, 8'h38},
        '{1'b0, 8'h38},
        '{1'b0, 8'h38},
        '{1'b0, 8'h0C},
        '{1'b0, 8'h01},
        '{1'b0, 8'h06}
    };

    // Clear display and return home need the long execution wait.
    function automatic logic is_long_exec(input lcd_inst_t inst);
        return !inst.rs && (inst.data == 8'h01 || inst.data == 8'h02 || inst.data == 8'h03);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Single down-counter shared by every timed state: load N, done is high on the
// N-th cycle after the load, then the counter parks at zero.
module lcd_delay_timer #(
    parameter int WIDTH       = 20,
    parameter int RESET_VALUE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= WIDTH'(RESET_VALUE);
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign done = (count == ONE);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// Avalon-MM slave turning single-byte instruction/data writes into HD44780 bus
// cycles, with automatic power-on initialisation after reset.
module lcd_hd44780_ctrl
    import lcd_inst_pkg::*;
#(
    parameter int POWER_ON_CYC  = 750000,
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 1,
    parameter int EXEC_CYC      = 2000,
    parameter int EXEC_LONG_CYC = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       address,
    input  logic       chipselect,
    input  logic       byteenable,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic       waitrequest,
    output logic [7:0] readdata,
    output logic [1:0] response,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic       LCD_BLON
);

    localparam int MAX_CYC = max_int(max_int(max_int(POWER_ON_CYC, SETUP_CYC),
                                             max_int(PULSE_CYC, HOLD_CYC)),
                                     max_int(EXEC_CYC, EXEC_LONG_CYC));
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [2:0] LAST_INIT = 3'(N_INIT - 1);

    state_t           state;
    lcd_inst_t        cur;
    logic [2:0]       init_idx;
    logic             in_init;
    logic [7:0]       inst_shadow;
    logic [7:0]       data_shadow;
    logic             wr_take;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_done;
    logic             unused;

    // Reads have no side effect: readdata is always valid from the shadows.
    assign unused = read;

    // A byteenable=0 write is still accepted in IDLE, it just does nothing.
    assign wr_take = (state == IDLE) && chipselect && write && byteenable;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            INIT_CMD: begin
                tmr_load  = 1'b1;
                tmr_value = CNT_W'(SETUP_CYC);
            end
            IDLE: begin
                tmr_load  = wr_take;
                tmr_value = CNT_W'(SETUP_CYC);
            end
            SETUP: begin
                tmr_load  = tmr_done;
                tmr_value = CNT_W'(PULSE_CYC);
            end
            PULSE: begin
                tmr_load  = tmr_done;
                tmr_value = CNT_W'(HOLD_CYC);
            end
            HOLD: begin
                tmr_load  = tmr_done;
                tmr_value = is_long_exec(cur) ? CNT_W'(EXEC_LONG_CYC) : CNT_W'(EXEC_CYC);
            end
            default: ;
        endcase
    end

    lcd_delay_timer #(
        .WIDTH       (CNT_W),
        .RESET_VALUE (POWER_ON_CYC)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= INIT_WAIT;
            cur         <= '0;
            init_idx    <= '0;
            in_init     <= 1'b1;
            LCD_EN      <= 1'b0;
            LCD_RS      <= 1'b0;
            LCD_DATA    <= 8'h00;
            // NOTE: the readdata shadows are plain registers, not RAM, so they
            // are cleared with the rest of the state.
            inst_shadow <= 8'h00;
            data_shadow <= 8'h00;
        end else begin
            case (state)
                INIT_WAIT: begin
                    if (tmr_done) state <= INIT_CMD;
                end
                INIT_CMD: begin
                    cur      <= INIT_ROM[init_idx];
                    LCD_RS   <= INIT_ROM[init_idx].rs;
                    LCD_DATA <= INIT_ROM[init_idx].data;
                    state    <= SETUP;
                end
                IDLE: begin
                    if (wr_take) begin
                        cur      <= '{address, writedata};
                        LCD_RS   <= address;
                        LCD_DATA <= writedata;
                        if (address) data_shadow <= writedata;
                        else         inst_shadow <= writedata;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tmr_done) begin
                        LCD_EN <= 1'b1;
                        state  <= PULSE;
                    end
                end
                PULSE: begin
                    if (tmr_done) begin
                        LCD_EN <= 1'b0;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (tmr_done) state <= EXEC_WAIT;
                end
                EXEC_WAIT: begin
                    if (tmr_done) begin
                        if (in_init && init_idx != LAST_INIT) begin
                            init_idx <= init_idx + 3'd1;
                            state    <= INIT_CMD;
                        end else begin
                            in_init <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= INIT_WAIT;
            endcase
        end
    end

    assign waitrequest = (state != IDLE);
    assign readdata    = address ? data_shadow : inst_shadow;
    assign response    = 2'b00;
    assign LCD_RW      = 1'b0;
    assign LCD_ON      = 1'b1;
    assign LCD_BLON    = 1'b1;

endmodule
